// File: rtl/layer2_pkg.sv
// Shared layer-2 constants, reader state encoding and window type.
package layer2_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_CH     = 32;
   localparam int WIDTH      = 13;
   localparam int HEIGHT     = 17;
   localparam int PAD_WIDTH  = WIDTH + 2;
   localparam int PAD_HEIGHT = HEIGHT + 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } rd_state_t;

   typedef logic [DATA_WIDTH-1:0] window_t [0:8];

   // Width of an index that counts 0..n-1 (never narrower than one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/padded_window_reader_index_counter.sv
// Nested channel / column / row counter for the window reader.
// Channel is the fastest index, then column, then row.
module window_index_counter #(
   parameter int NUM_CH = layer2_pkg::NUM_CH,
   parameter int HEIGHT = layer2_pkg::HEIGHT,
   parameter int WIDTH  = layer2_pkg::WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   i_clear,
   input  logic                                   i_advance,
   output logic [layer2_pkg::idx_w(HEIGHT)-1:0]   o_row,
   output logic [layer2_pkg::idx_w(WIDTH)-1:0]    o_col,
   output logic [layer2_pkg::idx_w(NUM_CH)-1:0]   o_ch,
   output logic [layer2_pkg::idx_w(HEIGHT)-1:0]   o_next_row,
   output logic [layer2_pkg::idx_w(WIDTH)-1:0]    o_next_col,
   output logic [layer2_pkg::idx_w(NUM_CH)-1:0]   o_next_ch,
   output logic                                   o_last_ch,
   output logic                                   o_last_pos,
   output logic                                   o_last_all
);
   import layer2_pkg::*;

   localparam int ROW_W = idx_w(HEIGHT);
   localparam int COL_W = idx_w(WIDTH);
   localparam int CH_W  = idx_w(NUM_CH);

   logic [ROW_W-1:0] r_row, w_next_row;
   logic [COL_W-1:0] r_col, w_next_col;
   logic [CH_W-1:0]  r_ch,  w_next_ch;
   logic             w_last_ch, w_last_col, w_last_row;

   // Wrap detection on the currently registered indices.
   always_comb begin
      w_last_ch  = (r_ch  == CH_W'(NUM_CH - 1));
      w_last_col = (r_col == COL_W'(WIDTH - 1));
      w_last_row = (r_row == ROW_W'(HEIGHT - 1));
   end

   // Following index: ch first, then col on ch wrap, then row on col wrap.
   always_comb begin
      w_next_ch  = r_ch;
      w_next_col = r_col;
      w_next_row = r_row;
      if (!w_last_ch) begin
         w_next_ch = r_ch + CH_W'(1);
      end else begin
         w_next_ch = {CH_W{1'b0}};
         if (!w_last_col) begin
            w_next_col = r_col + COL_W'(1);
         end else begin
            w_next_col = {COL_W{1'b0}};
            if (!w_last_row) begin
               w_next_row = r_row + ROW_W'(1);
            end else begin
               w_next_row = {ROW_W{1'b0}};
            end
         end
      end
   end

   // Index registers: clear returns to the frame origin, advance steps once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= {ROW_W{1'b0}};
         r_col <= {COL_W{1'b0}};
         r_ch  <= {CH_W{1'b0}};
      end else if (i_clear) begin
         r_row <= {ROW_W{1'b0}};
         r_col <= {COL_W{1'b0}};
         r_ch  <= {CH_W{1'b0}};
      end else if (i_advance) begin
         r_row <= w_next_row;
         r_col <= w_next_col;
         r_ch  <= w_next_ch;
      end else begin
         r_row <= r_row;
         r_col <= r_col;
         r_ch  <= r_ch;
      end
   end

   assign o_row      = r_row;
   assign o_col      = r_col;
   assign o_ch       = r_ch;
   assign o_next_row = w_next_row;
   assign o_next_col = w_next_col;
   assign o_next_ch  = w_next_ch;
   assign o_last_ch  = w_last_ch;
   assign o_last_pos = w_last_col & w_last_row;
   assign o_last_all = w_last_ch & w_last_col & w_last_row;

endmodule

// File: rtl/padded_window_reader.sv
// Streams 3x3 stride-1 windows out of zero-padded feature planes,
// ordered by output position (row-major) and then by channel.
module padded_window_reader #(
   parameter int DATA_WIDTH = layer2_pkg::DATA_WIDTH,
   parameter int NUM_CH     = layer2_pkg::NUM_CH,
   parameter int WIDTH      = layer2_pkg::WIDTH,
   parameter int HEIGHT     = layer2_pkg::HEIGHT,
   parameter int PAD_WIDTH  = WIDTH + 2,
   parameter int PAD_HEIGHT = HEIGHT + 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic [DATA_WIDTH-1:0]                  padded [0:NUM_CH-1][0:PAD_HEIGHT-1][0:PAD_WIDTH-1],
   output logic [DATA_WIDTH-1:0]                  win_data [0:8],
   output logic                                   win_valid,
   input  logic                                   win_ready,
   output logic [layer2_pkg::idx_w(HEIGHT)-1:0]   win_row,
   output logic [layer2_pkg::idx_w(WIDTH)-1:0]    win_col,
   output logic [layer2_pkg::idx_w(NUM_CH)-1:0]   win_ch,
   output logic                                   win_last_ch,
   output logic                                   busy,
   output logic                                   frame_done
);
   import layer2_pkg::*;

   localparam int ROW_W = idx_w(HEIGHT);
   localparam int COL_W = idx_w(WIDTH);
   localparam int CH_W  = idx_w(NUM_CH);
   localparam int PR_W  = idx_w(PAD_HEIGHT);
   localparam int PC_W  = idx_w(PAD_WIDTH);

   rd_state_t             r_state;
   logic                  r_win_valid;
   logic                  r_busy;
   logic                  r_frame_done;
   logic [DATA_WIDTH-1:0] r_win_data [0:8];

   logic [ROW_W-1:0]      w_row, w_next_row, w_sel_row;
   logic [COL_W-1:0]      w_col, w_next_col, w_sel_col;
   logic [CH_W-1:0]       w_ch,  w_next_ch,  w_sel_ch;
   logic                  w_last_ch, w_last_all;
   logic                  w_unused_last_pos;
   logic                  w_hs, w_start_ok, w_advance, w_finish;
   logic [PR_W-1:0]       w_pr_base;
   logic [PC_W-1:0]       w_pc_base;
   logic [DATA_WIDTH-1:0] w_window [0:8];

   window_index_counter #(
      .NUM_CH (NUM_CH),
      .HEIGHT (HEIGHT),
      .WIDTH  (WIDTH)
   ) u_index (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_finish),
      .i_advance  (w_advance),
      .o_row      (w_row),
      .o_col      (w_col),
      .o_ch       (w_ch),
      .o_next_row (w_next_row),
      .o_next_col (w_next_col),
      .o_next_ch  (w_next_ch),
      .o_last_ch  (w_last_ch),
      .o_last_pos (w_unused_last_pos),
      .o_last_all (w_last_all)
   );

   // Decode handshake events for the current state.
   always_comb begin
      w_hs       = r_win_valid & win_ready;
      w_start_ok = 1'b0;
      w_advance  = 1'b0;
      w_finish   = 1'b0;
      case (r_state)
         IDLE: begin
            w_start_ok = start;
         end
         STREAM: begin
            w_advance = w_hs & ~w_last_all;
            w_finish  = w_hs &  w_last_all;
         end
         DONE: begin
            w_start_ok = 1'b0;
         end
         default: begin
            w_start_ok = 1'b0;
         end
      endcase
   end

   // Window address: next index on an advance, otherwise the held index
   // (which is the frame origin while idle).
   always_comb begin
      if (w_advance) begin
         w_sel_row = w_next_row;
         w_sel_col = w_next_col;
         w_sel_ch  = w_next_ch;
      end else begin
         w_sel_row = w_row;
         w_sel_col = w_col;
         w_sel_ch  = w_ch;
      end
   end

   assign w_pr_base = PR_W'(w_sel_row);
   assign w_pc_base = PC_W'(w_sel_col);

   // Straight copy of the 3x3 neighbourhood; pad zeros come from the planes.
   for (genvar g_dr = 0; g_dr < 3; g_dr++) begin : g_win_row
      for (genvar g_dc = 0; g_dc < 3; g_dc++) begin : g_win_col
         assign w_window[3*g_dr + g_dc] =
            padded[w_sel_ch][w_pr_base + PR_W'(g_dr)][w_pc_base + PC_W'(g_dc)];
      end
   end

   // Reader FSM and registered window outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_win_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            r_win_data[k] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         case (r_state)
            IDLE: begin
               r_frame_done <= 1'b0;
               if (w_start_ok) begin
                  r_state     <= STREAM;
                  r_win_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_win_data  <= w_window;
               end
            end
            STREAM: begin
               if (w_finish) begin
                  r_state      <= DONE;
                  r_win_valid  <= 1'b0;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
                  for (int k = 0; k < 9; k++) begin
                     r_win_data[k] <= {DATA_WIDTH{1'b0}};
                  end
               end else if (w_advance) begin
                  r_win_data <= w_window;
               end
            end
            DONE: begin
               r_state      <= IDLE;
               r_frame_done <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_win_valid  <= 1'b0;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   assign win_data    = r_win_data;
   assign win_valid   = r_win_valid;
   assign win_row     = w_row;
   assign win_col     = w_col;
   assign win_ch      = w_ch;
   assign win_last_ch = w_last_ch & r_win_valid;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_padded_window_reader.sv
// Scoreboard bench: a small instance (2 ch, 3x3) exercises latency,
// backpressure, spurious starts and mid-frame reset; a default-size
// instance streams a full frame with zero borders.
module tb_padded_window_reader;

   localparam int SC = 2, SH = 3, SW = 3;
   localparam int DC = 32, DH = 17, DW = 13;

   typedef struct packed {
      logic [287:0] d;
      logic [7:0]   row;
      logic [7:0]   col;
      logic [7:0]   ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        start_s = 1'b0, ready_s = 1'b0;
   logic [31:0] pad_s [0:SC-1][0:SH+1][0:SW+1];
   logic [31:0] wd_s [0:8];
   logic        valid_s, last_s, busy_s, done_s;
   logic [1:0]  row_s, col_s;
   logic [0:0]  ch_s;

   logic        start_d = 1'b0, ready_d = 1'b0;
   logic [31:0] pad_d [0:DC-1][0:DH+1][0:DW+1];
   logic [31:0] wd_d [0:8];
   logic        valid_d, last_d, busy_d, done_d;
   logic [4:0]  row_d;
   logic [3:0]  col_d;
   logic [4:0]  ch_d;

   int checks = 0, errors = 0;
   int hs_s = 0, hs_d = 0, done_cnt_s = 0, border_seen = 0;
   exp_t exp_q_s[$], exp_q_d[$];
   logic [287:0] border_tl, border_br;

   padded_window_reader #(.DATA_WIDTH(32), .NUM_CH(SC), .WIDTH(SW), .HEIGHT(SH)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .padded(pad_s), .win_data(wd_s),
      .win_valid(valid_s), .win_ready(ready_s), .win_row(row_s), .win_col(col_s),
      .win_ch(ch_s), .win_last_ch(last_s), .busy(busy_s), .frame_done(done_s));

   padded_window_reader #(.DATA_WIDTH(32), .NUM_CH(DC), .WIDTH(DW), .HEIGHT(DH)) dut_d (
      .clk(clk), .rst_n(rst_n), .start(start_d), .padded(pad_d), .win_data(wd_d),
      .win_valid(valid_d), .win_ready(ready_d), .win_row(row_d), .win_col(col_d),
      .win_ch(ch_d), .win_last_ch(last_d), .busy(busy_d), .frame_done(done_d));

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   function automatic logic [287:0] pack9(input logic [31:0] w [0:8]);
      logic [287:0] v;
      for (int k = 0; k < 9; k++) v[k*32 +: 32] = w[k];
      return v;
   endfunction

   // Reference: window at output (r,c) of channel ch is padded[ch][r..r+2][c..c+2].
   function automatic logic [287:0] model_s(input int r, input int c, input int ch);
      logic [287:0] v;
      for (int k = 0; k < 9; k++) v[k*32 +: 32] = pad_s[ch][r + k/3][c + k%3];
      return v;
   endfunction

   function automatic logic [287:0] model_d(input int r, input int c, input int ch);
      logic [287:0] v;
      for (int k = 0; k < 9; k++) v[k*32 +: 32] = pad_d[ch][r + k/3][c + k%3];
      return v;
   endfunction

   task automatic push_frame_s();
      exp_t e;
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++)
            for (int ch = 0; ch < SC; ch++) begin
               e.d = model_s(r, c, ch); e.row = 8'(r); e.col = 8'(c); e.ch = 8'(ch);
               exp_q_s.push_back(e);
            end
   endtask

   task automatic push_frame_d();
      exp_t e;
      for (int r = 0; r < DH; r++)
         for (int c = 0; c < DW; c++)
            for (int ch = 0; ch < DC; ch++) begin
               e.d = model_d(r, c, ch); e.row = 8'(r); e.col = 8'(c); e.ch = 8'(ch);
               exp_q_d.push_back(e);
            end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor for the small instance: scoreboard pop, stall stability, done pulse.
   logic [287:0] hold_s;
   logic [7:0]   hold_idx_s;
   bit           stall_s = 1'b0;
   always @(negedge clk) begin
      logic [287:0] act;
      exp_t e;
      if (!rst_n) begin
         stall_s = 1'b0;
      end else begin
         act = pack9(wd_s);
         if (stall_s)
            chk(act == hold_s && {row_s, col_s, ch_s, 3'b000} == hold_idx_s && valid_s,
                "stall_hold_s", $sformatf("window changed under backpressure: %h (%0d,%0d,%0d)",
                act, row_s, col_s, ch_s));
         if (valid_s && ready_s) begin
            hs_s++;
            chk(exp_q_s.size() != 0, "unexpected_window_s",
                $sformatf("got (%0d,%0d,%0d) with nothing expected", row_s, col_s, ch_s));
            if (exp_q_s.size() != 0) begin
               e = exp_q_s.pop_front();
               chk(act == e.d && row_s == e.row && col_s == e.col && ch_s == e.ch &&
                   last_s == (e.ch == SC - 1), "window_s",
                   $sformatf("got (%0d,%0d,%0d,last=%0b) %h, expected (%0d,%0d,%0d) %h",
                   row_s, col_s, ch_s, last_s, act, e.row, e.col, e.ch, e.d));
            end
         end
         if (done_s) begin
            done_cnt_s++;
            chk(!busy_s && !valid_s, "done_busy_s",
                $sformatf("busy=%0b valid=%0b during frame_done, expected 0/0", busy_s, valid_s));
         end
         stall_s = valid_s && !ready_s;
         hold_s = act;
         hold_idx_s = {row_s, col_s, ch_s, 3'b000};
      end
   end

   // Monitor for the default instance: scoreboard pop plus border patterns.
   always @(negedge clk) begin
      logic [287:0] act;
      exp_t e;
      if (rst_n && valid_d && ready_d) begin
         act = pack9(wd_d);
         hs_d++;
         chk(exp_q_d.size() != 0, "unexpected_window_d",
             $sformatf("got (%0d,%0d,%0d) with nothing expected", row_d, col_d, ch_d));
         if (exp_q_d.size() != 0) begin
            e = exp_q_d.pop_front();
            chk(act == e.d && row_d == e.row[4:0] && col_d == e.col[3:0] && ch_d == e.ch[4:0] &&
                last_d == (e.ch == DC - 1), "window_d",
                $sformatf("got (%0d,%0d,%0d,last=%0b) %h, expected (%0d,%0d,%0d) %h",
                row_d, col_d, ch_d, last_d, act, e.row, e.col, e.ch, e.d));
         end
         if (row_d == 5'd0 && col_d == 4'd0) begin
            border_seen++;
            chk(act == border_tl, "border_top_left",
                $sformatf("ch %0d got %h, expected %h", ch_d, act, border_tl));
         end
         if (row_d == 5'd16 && col_d == 4'd12) begin
            border_seen++;
            chk(act == border_br, "border_bottom_right",
                $sformatf("ch %0d got %h, expected %h", ch_d, act, border_br));
         end
      end
   end

   // Run one small frame with given ready duty; optional spurious starts.
   task automatic run_frame_s(input int duty, input bit spur, input string tag);
      int  base;
      bit  got, f3, f10;
      base = hs_s; got = 1'b0; f3 = 1'b0; f10 = 1'b0;
      push_frame_s();
      start_s = 1'b1;
      ready_s = ($urandom_range(0, 99) < duty);
      for (int n = 0; n < 400; n++) begin
         tick();
         start_s = 1'b0;
         ready_s = ($urandom_range(0, 99) < duty);
         if (spur && !f3 && hs_s - base >= 3) begin start_s = 1'b1; f3 = 1'b1; end
         if (spur && !f10 && hs_s - base >= 10) begin start_s = 1'b1; f10 = 1'b1; end
         if (done_s) begin
            got = 1'b1;
            start_s = spur;
            break;
         end
      end
      chk(got, {"frame_done_seen_", tag}, "no frame_done within 400 cycles");
      chk(hs_s - base == SC*SH*SW, {"window_count_", tag},
          $sformatf("got %0d handshakes, expected %0d", hs_s - base, SC*SH*SW));
      tick();
      start_s = 1'b0;
      repeat (3) tick();
      chk(!valid_s && !busy_s, {"idle_after_frame_", tag},
          $sformatf("valid=%0b busy=%0b, expected 0/0", valid_s, busy_s));
      chk(exp_q_s.size() == 0, {"queue_drained_", tag},
          $sformatf("%0d windows never delivered", exp_q_s.size()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int  found, base, dbase, d0;
      bit  got;

      for (int c = 0; c < SC; c++)
         for (int i = 0; i < SH + 2; i++)
            for (int j = 0; j < SW + 2; j++)
               pad_s[c][i][j] = 32'(100*c + 10*i + j);
      for (int c = 0; c < DC; c++)
         for (int i = 0; i < DH + 2; i++)
            for (int j = 0; j < DW + 2; j++)
               pad_d[c][i][j] = (i == 0 || i == DH + 1 || j == 0 || j == DW + 1) ? 32'h0 : 32'hFFFF_FFFF;
      for (int k = 0; k < 9; k++) begin
         border_tl[k*32 +: 32] = (k == 4 || k == 5 || k == 7 || k == 8) ? 32'hFFFF_FFFF : 32'h0;
         border_br[k*32 +: 32] = (k == 0 || k == 1 || k == 3 || k == 4) ? 32'hFFFF_FFFF : 32'h0;
      end

      // Reset values
      repeat (3) tick();
      chk(!valid_s && !busy_s && !done_s && !last_s, "reset_ctrl_s",
          $sformatf("valid=%0b busy=%0b done=%0b last=%0b, expected all 0", valid_s, busy_s, done_s, last_s));
      chk(row_s == 2'd0 && col_s == 2'd0 && ch_s == 1'd0 && pack9(wd_s) == 288'd0, "reset_data_s",
          $sformatf("idx (%0d,%0d,%0d) data %h, expected zeros", row_s, col_s, ch_s, pack9(wd_s)));
      chk(!valid_d && !busy_d && !done_d && !last_d && row_d == 5'd0 && ch_d == 5'd0 &&
          pack9(wd_d) == 288'd0, "reset_d", "default instance outputs not zero in reset");
      rst_n = 1'b1;
      repeat (2) tick();

      // Start latency and a full frame with win_ready held high
      ready_s = 1'b1;
      push_frame_s();
      base = hs_s; d0 = done_cnt_s; found = -1;
      start_s = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (n == 0) chk(!valid_s, "latency_cycle0", $sformatf("valid=%0b at start cycle, expected 0", valid_s));
         if (n == 1) chk(valid_s && busy_s && ch_s == 1'd0 && wd_s[0] == 32'd0 && wd_s[4] == 32'd11 &&
                         wd_s[8] == 32'd22, "latency_cycle1",
                         $sformatf("valid=%0b busy=%0b ch=%0d d0=%0d d4=%0d d8=%0d, expected 1,1,0,0,11,22",
                         valid_s, busy_s, ch_s, wd_s[0], wd_s[4], wd_s[8]));
         if (n == 2) chk(ch_s == 1'd1 && wd_s[0] == 32'd100 && wd_s[8] == 32'd122, "second_window",
                         $sformatf("ch=%0d d0=%0d d8=%0d, expected 1,100,122", ch_s, wd_s[0], wd_s[8]));
         if (done_s) begin found = n; break; end
         tick();
         start_s = 1'b0;
      end
      chk(found == 19, "frame_done_latency", $sformatf("frame_done at cycle %0d, expected 19", found));
      chk(hs_s - base == 18, "full_frame_count", $sformatf("got %0d handshakes, expected 18", hs_s - base));
      repeat (4) tick();
      chk(done_cnt_s - d0 == 1, "frame_done_single", $sformatf("frame_done high %0d cycles, expected 1", done_cnt_s - d0));
      chk(exp_q_s.size() == 0, "queue_drained_a", $sformatf("%0d windows never delivered", exp_q_s.size()));

      // Random backpressure, 30% ready
      run_frame_s(30, 1'b0, "bp");
      // Spurious starts mid-frame and on the frame_done cycle
      run_frame_s(40, 1'b1, "spur");
      // Fresh start from idle begins at the origin again
      run_frame_s(100, 1'b0, "restart");

      // Reset in the middle of a frame
      push_frame_s();
      base = hs_s; got = 1'b0;
      ready_s = 1'b1; start_s = 1'b1;
      for (int n = 0; n < 50; n++) begin
         tick();
         start_s = 1'b0;
         if (hs_s - base >= 5) begin got = 1'b1; break; end
      end
      chk(got, "mid_reset_reach", "fewer than 5 handshakes within 50 cycles");
      #1 rst_n = 1'b0;
      #1;
      chk(!valid_s && !busy_s && !done_s && !last_s && row_s == 2'd0 && col_s == 2'd0 &&
          ch_s == 1'd0 && pack9(wd_s) == 288'd0, "mid_reset_outputs",
          $sformatf("valid=%0b busy=%0b idx (%0d,%0d,%0d) data %h, expected zeros",
          valid_s, busy_s, row_s, col_s, ch_s, pack9(wd_s)));
      exp_q_s.delete();
      tick();
      rst_n = 1'b1;
      tick();
      run_frame_s(100, 1'b0, "after_reset");

      // Default-size frame with zero borders, 70% ready
      push_frame_d();
      dbase = hs_d; got = 1'b0;
      start_d = 1'b1;
      ready_d = ($urandom_range(0, 99) < 70);
      for (int n = 0; n < 40000; n++) begin
         tick();
         start_d = 1'b0;
         ready_d = ($urandom_range(0, 99) < 70);
         if (done_d) begin got = 1'b1; break; end
      end
      chk(got, "frame_done_seen_d", "no frame_done within 40000 cycles");
      chk(hs_d - dbase == DH*DW*DC, "window_count_d",
          $sformatf("got %0d handshakes, expected %0d", hs_d - dbase, DH*DW*DC));
      chk(border_seen == 2*DC, "border_windows_seen",
          $sformatf("saw %0d border windows, expected %0d", border_seen, 2*DC));
      repeat (3) tick();
      chk(!valid_d && !busy_d && exp_q_d.size() == 0, "idle_after_frame_d",
          $sformatf("valid=%0b busy=%0b pending=%0d, expected 0/0/0", valid_d, busy_d, exp_q_d.size()));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
